aes_cbc_sequencer: RTL and testbench



---
 rtl/aes_cbc_sequencer_pkg.sv | 37 +++
 rtl/aes_cbc_sequencer_chain_reg.sv | 34 +++
 rtl/aes_cbc_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_aes_cbc_sequencer.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_cbc_sequencer_pkg.sv
// aes_seq_package: shared state encoding, control/flag bundles and the
// chaining-register reset value for aes_cbc_sequencer.
package aes_seq_package;

   localparam int SEQ_BLK_W = 128;
   localparam int SEQ_CNT_W = 16;

   // Value the chaining register takes on reset, soft clear and watchdog abort
   localparam logic [SEQ_BLK_W-1:0] IV_RST = 128'h000102030405060708090a0b0c0d0e0f;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_KEY      = 3'd1,
      S_WAIT_TXT = 3'd2,
      S_LOAD     = 3'd3,
      S_RUN      = 3'd4,
      S_OUT      = 3'd5
   } seq_state_t;

   // Job fields driven by the register-file controller
   typedef struct packed {
      logic                 clear;
      logic                 start;
      logic [SEQ_CNT_W-1:0] len;
      logic                 cbc_en;
      logic [SEQ_BLK_W-1:0] iv;
   } ctrl_seq_t;

   // Status reported back to the register-file controller
   typedef struct packed {
      logic                 busy;
      logic                 done;
      logic [SEQ_CNT_W-1:0] blk_cnt;
      logic                 err;
   } flags_seq_t;

endpackage

// File: rtl/aes_cbc_sequencer_chain_reg.sv
// aes_chain_reg: CBC chaining register plus the plaintext XOR.
// Priority: clear > load_iv > update.
module aes_chain_reg #(
   parameter int               BLK_W  = aes_seq_package::SEQ_BLK_W,
   parameter logic [BLK_W-1:0] IV_RST = aes_seq_package::IV_RST
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load_iv,
   input  logic [BLK_W-1:0] iv,
   input  logic             update,
   input  logic [BLK_W-1:0] upd_data,
   input  logic [BLK_W-1:0] text,
   output logic [BLK_W-1:0] chain,
   output logic [BLK_W-1:0] chained
);

   // Chain register: IV at job start, last ciphertext after each CBC block
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= IV_RST;
      end else if (clear) begin
         chain <= IV_RST;
      end else if (load_iv) begin
         chain <= iv;
      end else if (update) begin
         chain <= upd_data;
      end
   end

   assign chained = text ^ chain;

endmodule

// File: rtl/aes_cbc_sequencer.sv
// aes_cbc_sequencer: drives one AES-128 cipher core over a job of LEN blocks
// in ECB or CBC mode. Optional watchdog on the core: define
// AES_SEQ_WATCHDOG_EN to abort a job whose core never reports done.
//
// Handshakes (text, key, out): a transfer happens on a rising clock edge
// where valid and ready are both 1. Ready outputs are registered state
// decodes with no combinational path from any input; out_valid_o, once
// raised, stays high with out_data_o stable until out_ready_i is seen.
module aes_cbc_sequencer #(
   parameter int               BLK_W  = aes_seq_package::SEQ_BLK_W,
   parameter int               CNT_W  = aes_seq_package::SEQ_CNT_W,
   parameter logic [BLK_W-1:0] IV_RST = aes_seq_package::IV_RST
`ifdef AES_SEQ_WATCHDOG_EN
   ,
   parameter int               WDOG_CYC = 64
`endif
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic             cbc_en_i,
   input  logic [BLK_W-1:0] iv_i,
   input  logic             text_valid_i,
   output logic             text_ready_o,
   input  logic [BLK_W-1:0] text_i,
   input  logic             key_valid_i,
   output logic             key_ready_o,
   input  logic [BLK_W-1:0] key_i,
   output logic             core_ld_o,
   output logic [BLK_W-1:0] core_key_o,
   output logic [BLK_W-1:0] core_text_o,
   input  logic             core_done_i,
   input  logic [BLK_W-1:0] core_out_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [BLK_W-1:0] out_data_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] blk_cnt_o,
   output logic             err_o
);

   import aes_seq_package::*;

   ctrl_seq_t  ctrl;
   flags_seq_t flags;
   seq_state_t state;

   logic [CNT_W-1:0] len_q;
   logic             cbc_q;
   logic [CNT_W-1:0] blk_cnt_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic             key_ready_q;
   logic             text_ready_q;
   logic             ld_q;
   logic             out_valid_q;
   logic             done_q;
   logic [BLK_W-1:0] core_key_q;
   logic [BLK_W-1:0] core_text_q;
   logic [BLK_W-1:0] out_data_q;
   logic             err_q;
   logic             wdog_abort;
   logic             chain_clear;
   logic             chain_load;
   logic             chain_upd;
   logic [BLK_W-1:0] chain;
   logic [BLK_W-1:0] chained;

   assign ctrl.clear  = clear_i;
   assign ctrl.start  = start_i;
   assign ctrl.len    = len_i;
   assign ctrl.cbc_en = cbc_en_i;
   assign ctrl.iv     = iv_i;

   assign cnt_nxt = blk_cnt_q + CNT_W'(1);

   assign chain_clear = ctrl.clear | wdog_abort;
   assign chain_load  = (state == S_IDLE) & ctrl.start & ctrl.cbc_en;
   assign chain_upd   = (state == S_RUN) & core_done_i & cbc_q;

   aes_chain_reg #(
      .BLK_W  (BLK_W),
      .IV_RST (IV_RST)
   ) u_chain (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .clear    (chain_clear),
      .load_iv  (chain_load),
      .iv       (ctrl.iv),
      .update   (chain_upd),
      .upd_data (core_out_i),
      .text     (text_i),
      .chain    (chain),
      .chained  (chained)
   );

`ifdef AES_SEQ_WATCHDOG_EN
   localparam int WD_W = $clog2(WDOG_CYC) + 1;

   logic [WD_W-1:0] wdog_cnt;

   // Abort lands exactly WDOG_CYC cycles after the load pulse: the LOAD
   // cycle plus WDOG_CYC-1 RUN cycles without a done.
   assign wdog_abort = (state == S_RUN) & ~core_done_i &
                       (wdog_cnt == WD_W'(WDOG_CYC - 2));

   // Watchdog counter and sticky error flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wdog_cnt <= '0;
         err_q    <= 1'b0;
      end else if (ctrl.clear) begin
         wdog_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == S_IDLE && ctrl.start) begin
            err_q <= 1'b0;
         end else if (wdog_abort) begin
            err_q <= 1'b1;
         end
         if (state == S_LOAD) begin
            wdog_cnt <= '0;
         end else if (state == S_RUN) begin
            wdog_cnt <= wdog_cnt + WD_W'(1);
         end
      end
   end
`else
   assign wdog_abort = 1'b0;
   assign err_q      = 1'b0;
`endif

   // Main sequencing FSM with registered handshake, load and status outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= S_IDLE;
         len_q        <= '0;
         cbc_q        <= 1'b0;
         blk_cnt_q    <= '0;
         key_ready_q  <= 1'b0;
         text_ready_q <= 1'b0;
         ld_q         <= 1'b0;
         out_valid_q  <= 1'b0;
         done_q       <= 1'b0;
         core_key_q   <= '0;
         core_text_q  <= '0;
         out_data_q   <= '0;
      end else if (ctrl.clear) begin
         state        <= S_IDLE;
         len_q        <= '0;
         cbc_q        <= 1'b0;
         blk_cnt_q    <= '0;
         key_ready_q  <= 1'b0;
         text_ready_q <= 1'b0;
         ld_q         <= 1'b0;
         out_valid_q  <= 1'b0;
         done_q       <= 1'b0;
         core_key_q   <= '0;
         core_text_q  <= '0;
         out_data_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ctrl.start) begin
                  len_q       <= (ctrl.len == '0) ? CNT_W'(1) : ctrl.len;
                  cbc_q       <= ctrl.cbc_en;
                  blk_cnt_q   <= '0;
                  key_ready_q <= 1'b1;
                  state       <= S_KEY;
               end
            end
            S_KEY: begin
               if (key_valid_i) begin
                  core_key_q   <= key_i;
                  key_ready_q  <= 1'b0;
                  text_ready_q <= 1'b1;
                  state        <= S_WAIT_TXT;
               end
            end
            S_WAIT_TXT: begin
               if (text_valid_i) begin
                  core_text_q  <= cbc_q ? chained : text_i;
                  text_ready_q <= 1'b0;
                  ld_q         <= 1'b1;
                  state        <= S_LOAD;
               end
            end
            S_LOAD: begin
               ld_q  <= 1'b0;
               state <= S_RUN;
            end
            S_RUN: begin
               if (core_done_i) begin
                  out_data_q  <= core_out_i;
                  out_valid_q <= 1'b1;
                  state       <= S_OUT;
               end else if (wdog_abort) begin
                  state <= S_IDLE;
               end
            end
            S_OUT: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  blk_cnt_q   <= cnt_nxt;
                  if (cnt_nxt == len_q) begin
                     done_q <= 1'b1;
                     state  <= S_IDLE;
                  end else begin
                     text_ready_q <= 1'b1;
                     state        <= S_WAIT_TXT;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign flags.busy    = (state != S_IDLE);
   assign flags.done    = done_q;
   assign flags.blk_cnt = blk_cnt_q;
   assign flags.err     = err_q;

   assign key_ready_o  = key_ready_q;
   assign text_ready_o = text_ready_q;
   assign core_ld_o    = ld_q;
   assign core_key_o   = core_key_q;
   assign core_text_o  = core_text_q;
   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign busy_o       = flags.busy;
   assign done_o       = flags.done;
   assign blk_cnt_o    = flags.blk_cnt;
   assign err_o        = flags.err;

endmodule

// File: tb/tb_aes_cbc_sequencer.sv
// tb_aes_cbc_sequencer: bench for aes_cbc_sequencer with a behavioural
// AES-128 core model. Watchdog scenario is selected by AES_SEQ_WATCHDOG_EN.
module tb_aes_cbc_sequencer;

   localparam logic [127:0] IV_RST_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam int           WDOG_C   = 64;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         clear_i = 1'b0;
   logic         start_i = 1'b0;
   logic [15:0]  len_i = '0;
   logic         cbc_en_i = 1'b0;
   logic [127:0] iv_i = '0;
   logic         text_valid_i = 1'b0;
   logic         text_ready_o;
   logic [127:0] text_i = '0;
   logic         key_valid_i = 1'b0;
   logic         key_ready_o;
   logic [127:0] key_i = '0;
   logic         core_ld_o;
   logic [127:0] core_key_o;
   logic [127:0] core_text_o;
   logic         core_done_i = 1'b0;
   logic [127:0] core_out_i = '0;
   logic         out_valid_o;
   logic         out_ready_i = 1'b0;
   logic [127:0] out_data_o;
   logic         busy_o;
   logic         done_o;
   logic [15:0]  blk_cnt_o;
   logic         err_o;

   aes_cbc_sequencer dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .start_i      (start_i),
      .len_i        (len_i),
      .cbc_en_i     (cbc_en_i),
      .iv_i         (iv_i),
      .text_valid_i (text_valid_i),
      .text_ready_o (text_ready_o),
      .text_i       (text_i),
      .key_valid_i  (key_valid_i),
      .key_ready_o  (key_ready_o),
      .key_i        (key_i),
      .core_ld_o    (core_ld_o),
      .core_key_o   (core_key_o),
      .core_text_o  (core_text_o),
      .core_done_i  (core_done_i),
      .core_out_i   (core_out_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_data_o   (out_data_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .blk_cnt_o    (blk_cnt_o),
      .err_o        (err_o)
   );

   // ---------------- clock / reset / global time limit ----------------
   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc++;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, cyc=%0d", cyc);
      $fatal(1);
   end

   // ---------------- AES-128 reference ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] inv = 8'h01;
      if (a == 8'h00) inv = 8'h00;
      else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc = 8'h01;
      logic [31:0]  tmp;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               s[row + 4*c] = t[row + 4*((c + row) % 4)];
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // ---------------- core model ----------------
   int           core_lat = 3;
   bit           suppress = 1'b0;
   int           core_cd = 0;
   int           inject_req = 0;
   int           inject_ack = 0;
   logic [127:0] inject_val = '0;
   logic [127:0] cap_key, cap_text;
   logic [127:0] ld_text_q [$];
   logic [127:0] ld_key_q [$];
   int           ld_cyc = 0;
   int           done_cnt = 0;

   always @(negedge clk_i) begin
      core_done_i = 1'b0;
      if (inject_req != inject_ack) begin
         inject_ack  = inject_req;
         core_done_i = 1'b1;
         core_out_i  = inject_val;
      end else if (core_cd > 0) begin
         core_cd--;
         if (core_cd == 0 && !suppress) begin
            core_done_i = 1'b1;
            core_out_i  = aes_enc(cap_key, cap_text);
         end
      end
      if (core_ld_o) begin
         cap_key  = core_key_o;
         cap_text = core_text_o;
         ld_text_q.push_back(core_text_o);
         ld_key_q.push_back(core_key_o);
         ld_cyc   = cyc;
         core_cd  = core_lat;
      end
      if (done_o) done_cnt++;
   end

   // ---------------- scoreboard ----------------
   int           total = 0;
   int           bad = 0;
   logic [127:0] exp_q [$];
   logic [127:0] exp_ld_q [$];
   logic [127:0] pt_q [$];
   logic [127:0] got_q [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: wait expired at cycle %0d", name, cyc);
   endtask

   // ---------------- drivers ----------------
   task automatic do_start(input logic [15:0] len, input logic cbc, input logic [127:0] iv);
      @(negedge clk_i);
      len_i = len; cbc_en_i = cbc; iv_i = iv; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic send_key(input logic [127:0] k);
      int n = 0;
      key_i = k; key_valid_i = 1'b1;
      while (!key_ready_o && n < 100) begin @(negedge clk_i); n++; end
      if (!key_ready_o) timeout_fail("key_ready_wait");
      else @(negedge clk_i);
      key_valid_i = 1'b0;
   endtask

   task automatic send_text(input logic [127:0] t);
      int n = 0;
      text_i = t; text_valid_i = 1'b1;
      while (!text_ready_o && n < 100) begin @(negedge clk_i); n++; end
      if (!text_ready_o) timeout_fail("text_ready_wait");
      else @(negedge clk_i);
      text_valid_i = 1'b0;
   endtask

   task automatic recv_out(input int odelay, output logic [127:0] got);
      int           n = 0;
      bit           ok = 1'b1;
      logic [127:0] first;
      got = 'x;
      while (!out_valid_o && n < 300) begin @(negedge clk_i); n++; end
      if (!out_valid_o) begin
         timeout_fail("out_valid_wait");
         return;
      end
      first = out_data_o;
      for (int i = 0; i < odelay; i++) begin
         @(negedge clk_i);
         if (!out_valid_o || out_data_o !== first || text_ready_o) ok = 1'b0;
      end
      if (odelay > 0) check("backpressure_hold", ok, 1);
      got = out_data_o;
      out_ready_i = 1'b1;
      @(negedge clk_i);
      out_ready_i = 1'b0;
      check("valid_drop_after_hs", out_valid_o, 0);
   endtask

   // Full job: model results from the mode rules, then drive and compare.
   task automatic run_job(input logic [15:0] len, input logic cbc, input logic [127:0] key,
                          input logic [127:0] iv, input int odelay, input bit start_in_run);
      int           nblk = (len == 0) ? 1 : int'(len);
      logic [127:0] prev = iv;
      logic [127:0] blk_in, c, got;
      int           done_before;
      for (int b = 0; b < nblk; b++) begin
         blk_in = cbc ? (pt_q[b] ^ prev) : pt_q[b];
         c = aes_enc(key, blk_in);
         exp_ld_q.push_back(blk_in);
         exp_q.push_back(c);
         if (cbc) prev = c;
      end
      got_q.delete();
      done_before = done_cnt;
      do_start(len, cbc, iv);
      check("busy_after_start", busy_o, 1);
      send_key(key);
      for (int b = 0; b < nblk; b++) begin
         send_text(pt_q[b]);
         if (start_in_run) begin
            repeat (2) @(negedge clk_i);
            len_i = 16'd7; start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
            check("start_in_run_cnt", blk_cnt_o, b);
            check("start_in_run_busy", busy_o, 1);
         end
         recv_out(odelay, got);
         got_q.push_back(got);
         check("out_data", got, exp_q.pop_front());
         if (ld_text_q.size() == 0) begin
            timeout_fail("core_ld_missing");
            void'(exp_ld_q.pop_front());
         end else begin
            check("core_text_at_ld", ld_text_q.pop_front(), exp_ld_q.pop_front());
            check("core_key_at_ld", ld_key_q.pop_front(), key);
         end
         check("blk_cnt", blk_cnt_o, b + 1);
      end
      @(negedge clk_i);
      check("done_pulses", done_cnt - done_before, 1);
      check("ld_pulse_count", ld_text_q.size(), 0);
      check("busy_end", busy_o, 0);
   endtask

   // ---------------- table ----------------
   typedef struct packed {
      logic [15:0]  len;
      logic         cbc;
      logic [127:0] key;
      logic [127:0] iv;
      logic [127:0] pt;
      logic         has_exp;
      logic [127:0] exp0;
      logic [7:0]   lat;
      logic [7:0]   odelay;
   } vec_t;

   vec_t tbl [5];

   initial begin
      logic [127:0] k, v, p, x, got;
      int n;
      for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

      tbl[0] = '{16'd1, 1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h0,
                 128'h00112233445566778899aabbccddeeff, 1'b1,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 8'd3, 8'd0};
      tbl[1] = '{16'd1, 1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0,
                 128'h3243f6a8885a308d313198a2e0370734, 1'b1,
                 128'h3925841d02dc09fbdc118597196a0b32, 8'd1, 8'd10};
      tbl[2] = '{16'd0, 1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h0,
                 128'h00112233445566778899aabbccddeeff, 1'b1,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 8'd4, 8'd2};
      tbl[3] = '{16'd2, 1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                 128'h000102030405060708090a0b0c0d0e0f,
                 128'h00112233445566778899aabbccddeeff, 1'b0, 128'h0, 8'd2, 8'd1};
      tbl[4] = '{16'd3, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f,
                 128'h3243f6a8885a308d313198a2e0370734, 1'b0, 128'h0, 8'd5, 8'd3};

      // reset
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("rst_busy", busy_o, 0);
      check("rst_valid_ready_ld", {out_valid_o, key_ready_o, text_ready_o, core_ld_o, done_o}, 0);
      check("rst_blk_cnt", blk_cnt_o, 0);
      check("rst_core_key", core_key_o, 0);
      check("rst_core_text", core_text_o, 0);
      check("rst_out_data", out_data_o, 0);
      check("rst_err", err_o, 0);
      check("rst_chain", dut.u_chain.chain, IV_RST_C);

      // table-driven jobs
      for (int i = 0; i < 5; i++) begin
         n = (tbl[i].len == 0) ? 1 : int'(tbl[i].len);
         pt_q.delete();
         for (int b = 0; b < n; b++) pt_q.push_back(tbl[i].pt);
         core_lat = int'(tbl[i].lat);
         run_job(tbl[i].len, tbl[i].cbc, tbl[i].key, tbl[i].iv, int'(tbl[i].odelay), 1'b0);
         if (tbl[i].has_exp) check("table_vector", got_q[0], tbl[i].exp0);
         if (tbl[i].cbc) check("cbc_blocks_differ", got_q[0] != got_q[1], 1);
      end

      // start_i pulsed while the core runs
      core_lat = 10;
      pt_q.delete();
      pt_q.push_back(128'h00112233445566778899aabbccddeeff);
      run_job(16'd1, 1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h0, 0, 1'b1);

      // randomized jobs
      for (int j = 0; j < 8; j++) begin
         logic [15:0] len;
         len = 16'($urandom_range(0, 4));
         n = (len == 0) ? 1 : int'(len);
         k = {$urandom, $urandom, $urandom, $urandom};
         v = {$urandom, $urandom, $urandom, $urandom};
         pt_q.delete();
         for (int b = 0; b < n; b++) pt_q.push_back({$urandom, $urandom, $urandom, $urandom});
         core_lat = $urandom_range(1, 6);
         run_job(len, 1'($urandom_range(0, 1)), k, v, $urandom_range(0, 3), 1'b0);
      end

      // soft clear during RUN, then a stray core done
      suppress = 1'b1;
      core_lat = 5;
      k = {$urandom, $urandom, $urandom, $urandom};
      v = {$urandom, $urandom, $urandom, $urandom};
      do_start(16'd1, 1'b1, v);
      send_key(k);
      send_text(128'h0123456789abcdef0123456789abcdef);
      repeat (3) @(negedge clk_i);
      check("pre_clear_busy", busy_o, 1);
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      check("clear_busy", busy_o, 0);
      check("clear_chain", dut.u_chain.chain, IV_RST_C);
      check("clear_core_key", core_key_o, 0);
      inject_val = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
      inject_req++;
      repeat (3) @(negedge clk_i);
      check("stray_done_busy", busy_o, 0);
      check("stray_done_valid", out_valid_o, 0);
      check("stray_done_data", out_data_o, 0);
      check("stray_done_chain", dut.u_chain.chain, IV_RST_C);

      // asynchronous reset during RUN, then a late core done
      do_start(16'd2, 1'b1, v);
      send_key(k);
      send_text(128'h11111111222222223333333344444444);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b0;
      #2;
      check("rst_mid_run_busy", busy_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      inject_req++;
      repeat (3) @(negedge clk_i);
      check("late_done_valid", out_valid_o, 0);
      check("late_done_cnt", blk_cnt_o, 0);
      check("rst_mid_run_chain", dut.u_chain.chain, IV_RST_C);
      ld_text_q.delete();
      ld_key_q.delete();

`ifdef AES_SEQ_WATCHDOG_EN
      // core never answers: abort with sticky error
      begin
         int d0;
         d0 = done_cnt;
         do_start(16'd1, 1'b1, v);
         send_key(k);
         send_text(128'h55555555666666667777777788888888);
         n = 0;
         while (!err_o && n < 200) begin @(negedge clk_i); n++; end
         if (!err_o) timeout_fail("watchdog_err_wait");
         else check("watchdog_latency", cyc - ld_cyc, WDOG_C);
         check("watchdog_busy", busy_o, 0);
         check("watchdog_chain", dut.u_chain.chain, IV_RST_C);
         repeat (2) @(negedge clk_i);
         check("watchdog_no_done", done_cnt - d0, 0);
         check("watchdog_err_sticky", err_o, 1);
         do_start(16'd1, 1'b0, v);
         check("watchdog_err_cleared", err_o, 0);
         clear_i = 1'b1;
         @(negedge clk_i);
         clear_i = 1'b0;
      end
`else
      // without the watchdog the sequencer waits as long as it takes
      x = 128'h55555555666666667777777788888888 ^ v;
      do_start(16'd1, 1'b1, v);
      send_key(k);
      send_text(128'h55555555666666667777777788888888);
      repeat (WDOG_C + 40) @(negedge clk_i);
      check("nowd_still_busy", busy_o, 1);
      check("nowd_err", err_o, 0);
      check("nowd_no_valid", out_valid_o, 0);
      if (ld_text_q.size() == 0) timeout_fail("nowd_ld_missing");
      else check("nowd_core_text", ld_text_q.pop_front(), x);
      p = aes_enc(k, x);
      inject_val = p;
      inject_req++;
      recv_out(0, got);
      check("nowd_out_data", got, p);
      check("nowd_blk_cnt", blk_cnt_o, 1);
      @(negedge clk_i);
      check("nowd_idle", busy_o, 0);
`endif
      suppress = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
